// File: rtl/alu_exec_pkg.sv
// Shared op encodings for the integer execution stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_exec_pkg;

    localparam int OPW  = 6;
    localparam int XLEN = 32;

    typedef enum logic [OPW-1:0] {
        ALU_ADD  = 6'd0,
        ALU_SUB  = 6'd1,
        ALU_SLL  = 6'd2,
        ALU_SLT  = 6'd3,
        ALU_SLTU = 6'd4,
        ALU_XOR  = 6'd5,
        ALU_SRL  = 6'd6,
        ALU_SRA  = 6'd7,
        ALU_OR   = 6'd8,
        ALU_AND  = 6'd9,
        ALU_BEQ  = 6'd10,
        ALU_BNE  = 6'd11,
        ALU_BLT  = 6'd12,
        ALU_BGE  = 6'd13,
        ALU_BLTU = 6'd14,
        ALU_BGEU = 6'd15,
        ALU_JALR = 6'd16
    } alu_op_e;

    // Widen a condition bit into a 0/1 result word.
    function automatic logic [XLEN-1:0] flag32(input logic f);
        return {{(XLEN-1){1'b0}}, f};
    endfunction

endpackage

// File: rtl/alu_exec_core.sv
// Purely combinational 32-bit integer ALU: (op, a, b) -> result.
// Latency: 0 cycles.
// Backpressure: none; unknown ops produce zero.
module alu_exec_core
    import alu_exec_pkg::*;
(
    input  logic [OPW-1:0]  op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] sum;
    logic            lt_s;
    logic            lt_u;

    assign shamt = b[4:0];
    assign sum   = a + b;
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    // Decode the op; anything outside the table yields zero.
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = sum;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = flag32(lt_s);
            ALU_SLTU: result = flag32(lt_u);
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_BEQ:  result = flag32(a == b);
            ALU_BNE:  result = flag32(a != b);
            ALU_BLT:  result = flag32(lt_s);
            ALU_BGE:  result = flag32(!lt_s);
            ALU_BLTU: result = flag32(lt_u);
            ALU_BGEU: result = flag32(!lt_u);
            ALU_JALR: result = sum & ~32'd1;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execution stage: computes RS-issued ops and queues results for CDB broadcast.
// Latency: 1 cycle from accepted issue to out_valid when the buffer is empty.
// Backpressure: busy is raised whenever the result buffer is full (registered decode).
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int TAGW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            clear,
    input  logic            in_valid,
    input  logic [5:0]      in_op,
    input  logic [31:0]     in_rs1,
    input  logic [31:0]     in_rs2,
    input  logic [TAGW-1:0] in_rob,
    output logic            busy,
    input  logic            cdb_grant,
    output logic            out_valid,
    output logic [TAGW-1:0] out_rob,
    output logic [31:0]     out_val
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW:0] CNT_FULL = (PW+1)'(QDEPTH);

    logic [TAGW-1:0] rob_q [QDEPTH];
    logic [31:0]     val_q [QDEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [PW:0]     count_q;

    logic [31:0]     alu_res;
    logic            push;
    logic            pop;

    alu_exec_core u_core (
        .op     (in_op),
        .a      (in_rs1),
        .b      (in_rs2),
        .result (alu_res)
    );

    // Handshake decode from registered state only; stale head data is masked when empty.
    assign busy      = (count_q == CNT_FULL);
    assign out_valid = (count_q != '0);
    assign out_rob   = out_valid ? rob_q[head_q] : '0;
    assign out_val   = out_valid ? val_q[head_q] : '0;
    assign push      = in_valid && !busy;
    assign pop       = out_valid && cdb_grant;

    // Result buffer, pointers and occupancy; freeze on !rdy, flush on clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                rob_q[i] <= '0;
                val_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy) begin
            if (clear) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    rob_q[tail_q] <= in_rob;
                    val_q[tail_q] <= alu_res;
                    tail_q        <= tail_q + 1'b1;
                end
                if (pop) begin
                    head_q <= head_q + 1'b1;
                end
                if (push && !pop) begin
                    count_q <= count_q + 1'b1;
                end else if (pop && !push) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: arithmetic vectors, buffer handshake, clear, freeze, reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises full-buffer busy and dropped issues.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  in_op = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [3:0]  in_rob = '0;
    logic        busy;
    logic        cdb_grant = 1'b0;
    logic        out_valid;
    logic [3:0]  out_rob;
    logic [31:0] out_val;

    int n_checks = 0;
    int n_errors = 0;

    alu_exec #(.QDEPTH(2), .TAGW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rob    (in_rob),
        .busy      (busy),
        .cdb_grant (cdb_grant),
        .out_valid (out_valid),
        .out_rob   (out_rob),
        .out_val   (out_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_rob   = tag;
    endtask

    // Issue one op with grant held high, check the broadcast, then let it pop.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] rob, input logic [31:0] exp);
        issue(op, a, b, rob);
        step();
        in_valid = 1'b0;
        chk({tag, "_val"}, out_val, exp);
        chk({tag, "_rob"}, {28'd0, out_rob}, {28'd0, rob});
        step();
    endtask

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rob", {28'd0, out_rob}, 32'd0);
        chk("rst_val", out_val, 32'd0);

        // 1. ADD with latency 1, then pop
        cdb_grant = 1'b1;
        issue(6'd0, 32'd5, 32'd7, 4'd3);
        step();
        in_valid = 1'b0;
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_rob", {28'd0, out_rob}, 32'd3);
        chk("add_val", out_val, 32'd12);
        step();
        chk("add_popped", {31'd0, out_valid}, 32'd0);

        // 2/3. Arithmetic vectors
        run_op("sra",  6'd7,  32'h8000_0000, 32'd4, 4'd1, 32'hF800_0000);
        run_op("srl",  6'd6,  32'h8000_0000, 32'd4, 4'd2, 32'h0800_0000);
        run_op("sub",  6'd1,  32'd0, 32'd1, 4'd4, 32'hFFFF_FFFF);
        run_op("blt",  6'd12, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'd1);
        run_op("bltu", 6'd14, 32'hFFFF_FFFF, 32'd1, 4'd6, 32'd0);
        run_op("jalr", 6'd16, 32'h0000_1001, 32'd2, 4'd7, 32'h0000_1002);
        run_op("unk",  6'd63, 32'd9, 32'd9, 4'd8, 32'd0);
        run_op("sll",  6'd2,  32'h0000_0003, 32'd36, 4'd9, 32'h0000_0030);
        run_op("slt",  6'd3,  32'd1, 32'hFFFF_FFFF, 4'd10, 32'd0);
        run_op("bge",  6'd13, 32'd1, 32'hFFFF_FFFF, 4'd11, 32'd1);
        run_op("xor",  6'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 4'd12, 32'h0FF0_0FF0);

        // 4. Fill without grant, drop while busy, drain in order
        cdb_grant = 1'b0;
        issue(6'd0, 32'd4, 32'd6, 4'd1);
        step();
        issue(6'd0, 32'd15, 32'd5, 4'd2);
        step();
        in_valid = 1'b0;
        chk("full_busy", {31'd0, busy}, 32'd1);
        chk("full_head_rob", {28'd0, out_rob}, 32'd1);
        chk("full_head_val", out_val, 32'd10);
        issue(6'd0, 32'd90, 32'd9, 4'd5);
        step();
        in_valid = 1'b0;
        chk("drop_busy", {31'd0, busy}, 32'd1);
        chk("drop_head_rob", {28'd0, out_rob}, 32'd1);
        cdb_grant = 1'b1;
        step();
        cdb_grant = 1'b0;
        chk("pop1_rob", {28'd0, out_rob}, 32'd2);
        chk("pop1_val", out_val, 32'd20);
        chk("pop1_busy", {31'd0, busy}, 32'd0);
        cdb_grant = 1'b1;
        step();
        chk("drain_empty", {31'd0, out_valid}, 32'd0);

        // 5. Clear while full with same-cycle issue and grant
        cdb_grant = 1'b0;
        issue(6'd0, 32'd1, 32'd2, 4'd6);
        step();
        issue(6'd0, 32'd3, 32'd4, 4'd7);
        step();
        chk("pre_clr_busy", {31'd0, busy}, 32'd1);
        clear = 1'b1;
        cdb_grant = 1'b1;
        issue(6'd0, 32'd1, 32'd1, 4'd8);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        issue(6'd0, 32'd3, 32'd4, 4'd9);
        step();
        in_valid = 1'b0;
        chk("post_clr_rob", {28'd0, out_rob}, 32'd9);
        chk("post_clr_val", out_val, 32'd7);
        step();
        chk("post_clr_empty", {31'd0, out_valid}, 32'd0);

        // 6. Freeze with grant high and an ignored issue
        cdb_grant = 1'b0;
        issue(6'd0, 32'd100, 32'd1, 4'd10);
        step();
        in_valid = 1'b0;
        rdy = 1'b0;
        cdb_grant = 1'b1;
        issue(6'd0, 32'd50, 32'd0, 4'd11);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_valid", {31'd0, out_valid}, 32'd1);
            chk("frz_rob", {28'd0, out_rob}, 32'd10);
            chk("frz_val", out_val, 32'd101);
        end
        in_valid = 1'b0;
        rdy = 1'b1;
        step();
        chk("unfrz_pop", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream
        cdb_grant = 1'b0;
        issue(6'd0, 32'd8, 32'd8, 4'd12);
        step();
        issue(6'd0, 32'd9, 32'd9, 4'd13);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_rob", {28'd0, out_rob}, 32'd0);
        chk("mrst_val", out_val, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
